fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Shares the single write port of the ASYNC_FIFO between NUM_REQ requesters in the write clock domain.
//  Round-robin arbiter with burst/packet lock; drives winc/wData and back-pressures requesters on wFull.
//  Sits directly in front of ASYNC_FIFO winc/wData/wFull; read side untouched.
// PARAMETERS
//  NUM_REQ    4   number of requesters (>=2)
//  DATA_SIZE  12  data word width, equals ASYNC_FIFO DATA_SIZE
//  MAX_BURST  4   max words per grant before forced re-arbitration (>=1)
// PORTS
//  wclk       in   1                  write-domain clock
//  wrst       in   1                  synchronous, active-high reset
//  arb_en     in   1                  1 = new grants allowed; 0 = finish current grant, then idle
//  req_valid  in   NUM_REQ            per-requester word valid
//  req_last   in   NUM_REQ            per-requester end-of-packet, qualified by req_valid
//  req_data   in   NUM_REQ*DATA_SIZE  requester i data at [i*DATA_SIZE +: DATA_SIZE]
//  req_ready  out  NUM_REQ            per-requester word accepted this cycle
//  wFull      in   1                  FIFO full flag (registered in FIFO)
//  winc       out  1                  FIFO write strobe
//  wData      out  DATA_SIZE          FIFO write data
//  gnt_valid  out  1                  a grant is held
//  gnt_id     out  $clog2(NUM_REQ)    index of current owner, valid when gnt_valid
// BEHAVIOUR
//  Reset (wrst=1 at posedge wclk): state=ARB, gnt_valid=0, gnt_id=0, rr_ptr=0, beat_cnt=0.
//   Outputs then: winc=0, req_ready=0, wData=0.
//  States: ARB, BURST.
//  ARB: if arb_en & |req_valid, choose first valid index at or after rr_ptr (mod NUM_REQ).
//   Next cycle: gnt_id=choice, gnt_valid=1, beat_cnt=0, state=BURST. One-cycle arbitration latency.
//   No word is accepted in ARB.
//  BURST: accept = req_valid[gnt_id] & ~wFull.
//   winc = accept; req_ready[gnt_id] = accept; other req_ready bits 0.
//   wData = req_data[gnt_id] when gnt_valid, else 0. Combinational, zero-latency path to FIFO.
//   On each accept: beat_cnt++.
//   Release when accept & (req_last[gnt_id] | beat_cnt==MAX_BURST-1).
//   On release, next cycle: gnt_valid=0, rr_ptr=gnt_id+1 mod NUM_REQ, state=ARB.
//  wFull=1 in BURST: winc=0, req_ready=0, beat_cnt holds, grant held; resumes the cycle wFull drops.
//  Owner drops req_valid mid-burst without last: grant held (packet lock), nothing written.
//  arb_en has no effect on an active burst; it gates only the ARB->BURST transition.
//  Winc is never asserted while wFull=1; exactly one word is written per winc.
//  Data order within each requester is preserved.
//  Fairness: after an owner releases, every other requester with valid set is granted before it is re-granted.
//  rr_ptr and gnt_id wrap modulo NUM_REQ. beat_cnt width is $clog2(MAX_BURST+1).
//  Reset mid-burst: grant dropped, no winc in the reset cycle. Requester must resend the partial packet.
//  Requester i contract: hold req_data/req_last stable while req_valid[i]=1 and req_ready[i]=0.
// TESTING
//  1 Reset: wrst=1 for 2 cycles with all req_valid=1 -> winc=0, req_ready=0, gnt_valid=0 throughout.
//  2 Round robin: all 4 valid, each sends 1-word packets (last=1), wFull=0 ->
//    grant order 0,1,2,3,0; each word written one cycle after its grant.
//  3 Burst cap: req0 sends 6 words with no last, MAX_BURST=4 -> 4 winc pulses, release;
//    req0 re-granted only after any other valid requesters; remaining 2 words follow.
//  4 Full stall: wFull=1 for 3 cycles mid-burst of req2 -> winc=0 and req_ready[2]=0 for those cycles;
//    beat_cnt frozen; data sequence in FIFO unbroken.
//  5 arb_en=0 during req1 burst -> burst completes to last; no new grant while arb_en=0;
//    grant to the next requester one cycle after arb_en=1.
//  6 wrst pulse mid-burst (beat 2 of 4) -> gnt_valid=0 next cycle, rr_ptr=0;
//    arbitration restarts from index 0.

Source files
------------

// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ requesters, the arbiter and the ASYNC_FIFO write port.
// Latency: none; this is wiring only.
// Backpressure: req_ready/winc are driven by the arbiter, wFull comes from the FIFO.
// Ports: master = requesters + FIFO (drive valid/last/data/wFull/arb_en),
//        slave  = arbiter (drives ready/winc/wData/grant status).
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 12
);
  localparam int IDW = $clog2(NUM_REQ);

  logic                          arb_en;
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*DATA_SIZE-1:0]  req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          wFull;
  logic                          winc;
  logic [DATA_SIZE-1:0]          wData;
  logic                          gnt_valid;
  logic [IDW-1:0]                gnt_id;

  modport master (
    output arb_en, req_valid, req_last, req_data, wFull,
    input  req_ready, winc, wData, gnt_valid, gnt_id
  );

  modport slave (
    input  arb_en, req_valid, req_last, req_data, wFull,
    output req_ready, winc, wData, gnt_valid, gnt_id
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the ASYNC_FIFO write port; grants are locked per packet/burst.
// Latency: one cycle ARB->BURST; data path to winc/wData is combinational once granted.
// Backpressure: wFull stalls the owner (req_ready=0, winc=0); non-owners always see req_ready=0.
// Ports: wclk/wrst  write clock and synchronous active-high reset
//        bus        slave side of fifo_wr_arbiter_if (requester handshakes, FIFO write port, grant status)
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 12,
  parameter int MAX_BURST = 4
) (
  input  logic              wclk,
  input  logic              wrst,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int BCW = $clog2(MAX_BURST + 1);
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);

  typedef enum logic {ARB, BURST} state_t;

  state_t          state_q,    state_d;
  logic [IDW-1:0]  gnt_id_q,   gnt_id_d;
  logic [IDW-1:0]  rr_ptr_q,   rr_ptr_d;
  logic [BCW-1:0]  beat_cnt_q, beat_cnt_d;

  logic            pick_vld;
  logic [IDW-1:0]  pick_id;
  logic            accept;
  logic            release_gnt;
  logic [IDW-1:0]  gnt_id_inc;

  logic [DATA_SIZE-1:0] req_word [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_word[g] = bus.req_data[g*DATA_SIZE +: DATA_SIZE];
  end

  // Scan from the highest offset down so the first valid index at or after
  // rr_ptr is the last one to be written and therefore wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      logic [IDW-1:0] idx;
      idx = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (bus.req_valid[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

  // wrst gates the strobe so a word is never written in the cycle the grant is torn down.
  assign accept      = (state_q == BURST) & bus.req_valid[gnt_id_q] & ~bus.wFull & ~wrst;
  assign release_gnt = accept & (bus.req_last[gnt_id_q] | (beat_cnt_q == LAST_BEAT));
  assign gnt_id_inc  = (gnt_id_q == IDW'(NUM_REQ - 1)) ? '0 : gnt_id_q + IDW'(1);

  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB: begin
        if (bus.arb_en && pick_vld) begin
          state_d    = BURST;
          gnt_id_d   = pick_id;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + BCW'(1);
        end
        // Pointer moves past the owner so everyone else gets a turn first.
        if (release_gnt) begin
          state_d  = ARB;
          rr_ptr_d = gnt_id_inc;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q    <= ARB;
      gnt_id_q   <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign bus.winc      = accept;
  assign bus.req_ready = accept ? (NUM_REQ'(1) << gnt_id_q) : '0;
  assign bus.wData     = (state_q == BURST) ? req_word[gnt_id_q] : '0;
  assign bus.gnt_valid = (state_q == BURST);
  assign bus.gnt_id    = gnt_id_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle grant/strobe tables and FIFO write log per scenario.
// Latency: checks sampled 2 time units after each rising edge.
// Backpressure: wFull is driven from per-cycle tables; requesters pop only on req_ready.
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 12;
  localparam int MB = 4;

  logic wclk = 1'b0;
  logic wrst = 1'b1;
  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_SIZE(DW)) bus();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DW), .MAX_BURST(MB)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Per-requester word queues: {last, data}.
  logic [DW:0]   rmem [NR][8];
  int            head [NR];
  int            tail [NR];
  logic [DW-1:0] wlog [$];

  task automatic clear_all();
    for (int i = 0; i < NR; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    wlog.delete();
  endtask

  task automatic push(input int i, input logic [DW-1:0] d, input logic last);
    rmem[i][tail[i]] = {last, d};
    tail[i]++;
  endtask

  task automatic drive();
    logic [NR-1:0]    v;
    logic [NR-1:0]    l;
    logic [NR*DW-1:0] dat;
    v = '0; l = '0; dat = '0;
    for (int i = 0; i < NR; i++) begin
      if (head[i] < tail[i]) begin
        v[i] = 1'b1;
        l[i] = rmem[i][head[i]][DW];
        dat[i*DW +: DW] = rmem[i][head[i]][DW-1:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = dat;
  endtask

  // Capture the handshake just before the edge, then advance requesters and the FIFO log.
  task automatic step();
    logic [NR-1:0] rdy;
    logic          w;
    logic [DW-1:0] d;
    rdy = bus.req_ready;
    w   = bus.winc;
    d   = bus.wData;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NR; i++) if (rdy[i]) head[i]++;
    if (w) wlog.push_back(d);
    drive();
  endtask

  task automatic test_reset();
    clear_all();
    for (int i = 0; i < NR; i++) push(i, DW'(12'h010 + i), 1'b1);
    bus.wFull  = 1'b0;
    bus.arb_en = 1'b1;
    wrst       = 1'b1;
    drive();
    for (int c = 0; c < 2; c++) begin
      step();
      #1;
      checks++; if (bus.winc !== 1'b0) begin errors++; $display("FAIL reset winc cyc %0d got %b exp 0", c, bus.winc); end
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset req_ready cyc %0d got %b exp 0000", c, bus.req_ready); end
      checks++; if (bus.gnt_valid !== 1'b0) begin errors++; $display("FAIL reset gnt_valid cyc %0d got %b exp 0", c, bus.gnt_valid); end
    end
    checks++; if (bus.gnt_id !== 2'd0) begin errors++; $display("FAIL reset gnt_id got %0d exp 0", bus.gnt_id); end
    checks++; if (bus.wData !== 12'h000) begin errors++; $display("FAIL reset wData got %h exp 000", bus.wData); end
    wrst = 1'b0;
    clear_all();
    drive();
    step();
  endtask

  task automatic test_round_robin();
    bit       gv [10] = '{0,1,0,1,0,1,0,1,0,1};
    bit [1:0] id [10] = '{0,0,0,1,0,2,0,3,0,0};
    logic [DW-1:0] ew [5] = '{12'h020, 12'h120, 12'h220, 12'h320, 12'h021};
    logic [NR-1:0] er;
    clear_all();
    push(0, 12'h020, 1'b1); push(0, 12'h021, 1'b1);
    push(1, 12'h120, 1'b1); push(2, 12'h220, 1'b1); push(3, 12'h320, 1'b1);
    drive();
    for (int k = 0; k < 10; k++) begin
      #1;
      er = gv[k] ? (4'b0001 << id[k]) : 4'b0000;
      checks++; if (bus.gnt_valid !== gv[k]) begin errors++; $display("FAIL rr gnt_valid cyc %0d got %b exp %b", k, bus.gnt_valid, gv[k]); end
      checks++; if (bus.winc !== gv[k]) begin errors++; $display("FAIL rr winc cyc %0d got %b exp %b", k, bus.winc, gv[k]); end
      checks++; if (bus.req_ready !== er) begin errors++; $display("FAIL rr req_ready cyc %0d got %b exp %b", k, bus.req_ready, er); end
      if (gv[k]) begin
        checks++; if (bus.gnt_id !== id[k]) begin errors++; $display("FAIL rr gnt_id cyc %0d got %0d exp %0d", k, bus.gnt_id, id[k]); end
      end
      step();
    end
    checks++; if (wlog.size() != 5) begin errors++; $display("FAIL rr write count got %0d exp 5", wlog.size()); end
    for (int j = 0; j < 5 && j < wlog.size(); j++) begin
      checks++; if (wlog[j] !== ew[j]) begin errors++; $display("FAIL rr write %0d got %h exp %h", j, wlog[j], ew[j]); end
    end
  endtask

  task automatic test_burst_cap();
    bit       gv [12] = '{0,1,1,1,1,0,1,0,1,0,1,1};
    bit [1:0] id [12] = '{0,0,0,0,0,0,1,0,3,0,0,0};
    logic [DW-1:0] ew [8] = '{12'h030, 12'h031, 12'h032, 12'h033, 12'h130, 12'h330, 12'h034, 12'h035};
    logic [NR-1:0] er;
    clear_all();
    for (int j = 0; j < 6; j++) push(0, DW'(12'h030 + j), (j == 5));
    drive();
    for (int k = 0; k < 12; k++) begin
      #1;
      er = gv[k] ? (4'b0001 << id[k]) : 4'b0000;
      checks++; if (bus.gnt_valid !== gv[k]) begin errors++; $display("FAIL cap gnt_valid cyc %0d got %b exp %b", k, bus.gnt_valid, gv[k]); end
      checks++; if (bus.winc !== gv[k]) begin errors++; $display("FAIL cap winc cyc %0d got %b exp %b", k, bus.winc, gv[k]); end
      checks++; if (bus.req_ready !== er) begin errors++; $display("FAIL cap req_ready cyc %0d got %b exp %b", k, bus.req_ready, er); end
      if (gv[k]) begin
        checks++; if (bus.gnt_id !== id[k]) begin errors++; $display("FAIL cap gnt_id cyc %0d got %0d exp %0d", k, bus.gnt_id, id[k]); end
      end
      // Competitors show up only after req0 already owns the port.
      if (k == 0) begin
        push(1, 12'h130, 1'b1);
        push(3, 12'h330, 1'b1);
      end
      step();
    end
    checks++; if (wlog.size() != 8) begin errors++; $display("FAIL cap write count got %0d exp 8", wlog.size()); end
    for (int j = 0; j < 8 && j < wlog.size(); j++) begin
      checks++; if (wlog[j] !== ew[j]) begin errors++; $display("FAIL cap write %0d got %h exp %h", j, wlog[j], ew[j]); end
    end
  endtask

  task automatic test_full_stall();
    bit full [11] = '{0,0,1,1,1,0,0,0,0,0,0};
    bit gv   [11] = '{0,1,1,1,1,1,1,1,0,1,0};
    bit wi   [11] = '{0,1,0,0,0,1,1,1,0,1,0};
    logic [NR-1:0] er;
    clear_all();
    for (int j = 0; j < 5; j++) push(2, DW'(12'h240 + j), (j == 4));
    drive();
    for (int k = 0; k < 11; k++) begin
      bus.wFull = full[k];
      #1;
      er = wi[k] ? 4'b0100 : 4'b0000;
      checks++; if (bus.gnt_valid !== gv[k]) begin errors++; $display("FAIL full gnt_valid cyc %0d got %b exp %b", k, bus.gnt_valid, gv[k]); end
      checks++; if (bus.winc !== wi[k]) begin errors++; $display("FAIL full winc cyc %0d got %b exp %b", k, bus.winc, wi[k]); end
      checks++; if (bus.req_ready !== er) begin errors++; $display("FAIL full req_ready cyc %0d got %b exp %b", k, bus.req_ready, er); end
      if (gv[k]) begin
        checks++; if (bus.gnt_id !== 2'd2) begin errors++; $display("FAIL full gnt_id cyc %0d got %0d exp 2", k, bus.gnt_id); end
      end
      step();
    end
    bus.wFull = 1'b0;
    checks++; if (wlog.size() != 5) begin errors++; $display("FAIL full write count got %0d exp 5", wlog.size()); end
    for (int j = 0; j < 5 && j < wlog.size(); j++) begin
      checks++; if (wlog[j] !== DW'(12'h240 + j)) begin errors++; $display("FAIL full write %0d got %h exp %h", j, wlog[j], DW'(12'h240 + j)); end
    end
  endtask

  task automatic test_arb_en();
    bit       en [9] = '{1,0,0,0,0,0,1,1,1};
    bit       gv [9] = '{0,1,1,1,0,0,0,1,0};
    bit [1:0] id [9] = '{0,1,1,1,0,0,0,2,0};
    logic [DW-1:0] ew [4] = '{12'h150, 12'h151, 12'h152, 12'h250};
    logic [NR-1:0] er;
    clear_all();
    for (int j = 0; j < 3; j++) push(1, DW'(12'h150 + j), (j == 2));
    push(2, 12'h250, 1'b1);
    drive();
    for (int k = 0; k < 9; k++) begin
      bus.arb_en = en[k];
      #1;
      er = gv[k] ? (4'b0001 << id[k]) : 4'b0000;
      checks++; if (bus.gnt_valid !== gv[k]) begin errors++; $display("FAIL en gnt_valid cyc %0d got %b exp %b", k, bus.gnt_valid, gv[k]); end
      checks++; if (bus.winc !== gv[k]) begin errors++; $display("FAIL en winc cyc %0d got %b exp %b", k, bus.winc, gv[k]); end
      checks++; if (bus.req_ready !== er) begin errors++; $display("FAIL en req_ready cyc %0d got %b exp %b", k, bus.req_ready, er); end
      if (gv[k]) begin
        checks++; if (bus.gnt_id !== id[k]) begin errors++; $display("FAIL en gnt_id cyc %0d got %0d exp %0d", k, bus.gnt_id, id[k]); end
      end
      step();
    end
    bus.arb_en = 1'b1;
    checks++; if (wlog.size() != 4) begin errors++; $display("FAIL en write count got %0d exp 4", wlog.size()); end
    for (int j = 0; j < 4 && j < wlog.size(); j++) begin
      checks++; if (wlog[j] !== ew[j]) begin errors++; $display("FAIL en write %0d got %h exp %h", j, wlog[j], ew[j]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    bit       rs [10] = '{0,0,0,1,0,0,0,0,0,0};
    bit       gv [10] = '{0,1,1,1,0,1,0,1,1,0};
    bit [1:0] id [10] = '{0,3,3,3,0,0,0,3,3,0};
    bit       wi [10] = '{0,1,1,0,0,1,0,1,1,0};
    logic [DW-1:0] ew [5] = '{12'h360, 12'h361, 12'h060, 12'h362, 12'h363};
    logic [NR-1:0] er;
    clear_all();
    for (int j = 0; j < 4; j++) push(3, DW'(12'h360 + j), (j == 3));
    push(0, 12'h060, 1'b1);
    drive();
    for (int k = 0; k < 10; k++) begin
      wrst = rs[k];
      #1;
      er = wi[k] ? (4'b0001 << id[k]) : 4'b0000;
      checks++; if (bus.gnt_valid !== gv[k]) begin errors++; $display("FAIL rst gnt_valid cyc %0d got %b exp %b", k, bus.gnt_valid, gv[k]); end
      checks++; if (bus.winc !== wi[k]) begin errors++; $display("FAIL rst winc cyc %0d got %b exp %b", k, bus.winc, wi[k]); end
      checks++; if (bus.req_ready !== er) begin errors++; $display("FAIL rst req_ready cyc %0d got %b exp %b", k, bus.req_ready, er); end
      if (gv[k]) begin
        checks++; if (bus.gnt_id !== id[k]) begin errors++; $display("FAIL rst gnt_id cyc %0d got %0d exp %0d", k, bus.gnt_id, id[k]); end
      end
      step();
    end
    wrst = 1'b0;
    checks++; if (wlog.size() != 5) begin errors++; $display("FAIL rst write count got %0d exp 5", wlog.size()); end
    for (int j = 0; j < 5 && j < wlog.size(); j++) begin
      checks++; if (wlog[j] !== ew[j]) begin errors++; $display("FAIL rst write %0d got %h exp %h", j, wlog[j], ew[j]); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_burst_cap();
    test_full_stall();
    test_arb_en();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
